rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter REGISTER_ADDRESS_WIDTH, default 5, SHALL set the register address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the write data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 s_reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 hold  input  1  SHALL be the pipeline stall; while high, no request is granted.
REQ-006 req_valid  input  2  SHALL carry the per-requester write request (bit 0 is ALU writeback, bit 1 is LSU writeback).
REQ-007 req_ready  output  2  SHALL carry the per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_address  input  2 x REGISTER_ADDRESS_WIDTH  SHALL carry the destination register per requester.
REQ-009 req_data  input  2 x DATA_WIDTH  SHALL carry the write value per requester.
REQ-010 rf_we  output  1  SHALL drive the register file write enable.
REQ-011 rf_address  output  REGISTER_ADDRESS_WIDTH  SHALL drive the register file write address.
REQ-012 rf_write_data  output  DATA_WIDTH  SHALL drive the register file write data.

Function
REQ-013 req_ready SHALL be combinational from req_valid, hold, s_reset and the priority pointer, and SHALL be one-hot or zero.
REQ-014 req_ready[i] SHALL be low when hold or s_reset is high.
REQ-015 With exactly one requester valid and hold low, that requester SHALL be granted in the same cycle.
REQ-016 With both requesters valid and hold low, the requester selected by the 1-bit round-robin pointer rr_ptr SHALL be granted; rr_ptr=0 favours requester 0.
REQ-017 After a transfer from requester i, rr_ptr SHALL become the other requester's index on the next edge; rr_ptr SHALL be unchanged otherwise.
REQ-018 A transfer SHALL be registered: rf_we, rf_address and rf_write_data reflect the granted request exactly one cycle after the transfer (latency 1).
REQ-019 rf_we SHALL be high for exactly one cycle per transfer whose address is non-zero.
REQ-020 A transfer to address 0 SHALL be accepted (ready high) but SHALL produce rf_we=0; rr_ptr still advances.
REQ-021 When no transfer occurs, rf_we SHALL be 0 in the next cycle; rf_address and rf_write_data SHALL hold their last values.
REQ-022 Requesters SHALL keep req_valid, req_address and req_data stable until the transfer; an ungranted requester is not dropped.
REQ-023 Back-to-back transfers to the same address SHALL be issued in grant order, so the later grant wins in the register file.
REQ-024 Sustained throughput SHALL be one write per cycle; with both valid and no hold, grants SHALL alternate 0,1,0,1 or 1,0,1,0.

Reset
REQ-025 While s_reset is high on a clock edge: rf_we=0, rf_address=0, rf_write_data=0 and rr_ptr=0 on the next cycle.
REQ-026 A request pending during reset SHALL NOT be transferred, and SHALL be granted normally in the first cycle after s_reset falls.

Configuration
REQ-027 Macro RF_WB_ARBITER_CONFLICT_CNT_EN, when defined, SHALL add output conflict_count (16 bits), reset to 0, incremented once per cycle in which both req_valid bits are high and hold is low, saturating at 16'hFFFF.
REQ-028 Without RF_WB_ARBITER_CONFLICT_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package rf_pkg SHALL hold REGISTER_ADDRESS_WIDTH, DATA_WIDTH, the rf_addr_t and rf_data_t typedefs, and the requester index constants REQ_ALU=0 and REQ_LSU=1.
REQ-030 Round-robin grant logic SHALL be a sub-module rf_rr_grant2 (inputs: valid, hold, rr_ptr; output: one-hot grant).

Verification
REQ-031 Reset: hold s_reset 2 cycles with req_valid=2'b11 -> req_ready=0 throughout, rf_we=0, and after release requester 0 is granted first.
REQ-032 Single request: req_valid=01, addr 5, data 32'hDEADBEEF -> req_ready=01 same cycle; next cycle rf_we=1, rf_address=5, rf_write_data=32'hDEADBEEF.
REQ-033 Contention: req_valid=11 held for 4 cycles (addr 3/7, data 32'h11/32'h22) -> grants 0,1,0,1; rf_address sequence 3,7,3,7.
REQ-034 Zero address: requester 1 with addr 0, data 32'hFFFF_FFFF -> req_ready[1]=1, next cycle rf_we=0, rr_ptr=0.
REQ-035 Hold: req_valid=11, hold=1 for 3 cycles -> no grants, rf_we=0, rr_ptr unchanged; hold falls -> the rr_ptr requester is granted that cycle.
REQ-036 With RF_WB_ARBITER_CONFLICT_CNT_EN: 10 cycles of req_valid=11 with hold low, then 5 with hold high -> conflict_count=10.

Source files
------------

// File: rtl/rf_pkg.sv
//==============================================================================
// Module      : rf_pkg
// Description : Shared widths, types and requester indices for the register
//               file writeback arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_pkg;

    localparam int REGISTER_ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH             = 32;
    localparam int NUM_REQ                = 2;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    typedef logic [REGISTER_ADDRESS_WIDTH-1:0] rf_addr_t;
    typedef logic [DATA_WIDTH-1:0]             rf_data_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
//==============================================================================
// Module      : rf_wb_arbiter_if
// Description : Writeback request bus (two requesters) and register file write
//               port. master = requester/regfile side, slave = arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
    parameter int REGISTER_ADDRESS_WIDTH = rf_pkg::REGISTER_ADDRESS_WIDTH,
    parameter int DATA_WIDTH             = rf_pkg::DATA_WIDTH
);

    logic [1:0]                             req_valid;
    logic [1:0]                             req_ready;
    logic [1:0][REGISTER_ADDRESS_WIDTH-1:0] req_address;
    logic [1:0][DATA_WIDTH-1:0]             req_data;

    logic                                   rf_we;
    logic [REGISTER_ADDRESS_WIDTH-1:0]      rf_address;
    logic [DATA_WIDTH-1:0]                  rf_write_data;

    modport master (
        output req_valid, req_address, req_data,
        input  req_ready, rf_we, rf_address, rf_write_data
    );

    modport slave (
        input  req_valid, req_address, req_data,
        output req_ready, rf_we, rf_address, rf_write_data
    );

endinterface

`default_nettype wire

// File: rtl/rf_rr_grant2.sv
//==============================================================================
// Module      : rf_rr_grant2
// Description : Two-way round-robin grant; one-hot or zero, suppressed by hold.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_rr_grant2
    import rf_pkg::*;
(
    input  wire logic [1:0] valid,
    input  wire logic       hold,
    input  wire logic       rr_ptr,
    output logic      [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            // Only contention consults the pointer; a lone requester always wins.
            if (valid[REQ_ALU] && valid[REQ_LSU]) begin
                grant[rr_ptr] = 1'b1;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
//==============================================================================
// Module      : rf_wb_arbiter
// Description : Arbitrates ALU/LSU writebacks onto one register file write port
//               with a registered (latency 1) write. Optional saturating
//               contention counter enabled by RF_WB_ARBITER_CONFLICT_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_wb_arbiter #(
    parameter int REGISTER_ADDRESS_WIDTH = rf_pkg::REGISTER_ADDRESS_WIDTH,
    parameter int DATA_WIDTH             = rf_pkg::DATA_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      s_reset,
    input  wire logic      hold,
    rf_wb_arbiter_if.slave bus
`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
    ,
    output logic [15:0]    conflict_count
`endif
);

    logic                              r_rr_ptr;
    logic                              r_rf_we;
    logic [REGISTER_ADDRESS_WIDTH-1:0] r_rf_address;
    logic [DATA_WIDTH-1:0]             r_rf_write_data;

    logic [1:0]                        w_grant;
    logic                              w_xfer;
    logic                              w_sel;
    logic [REGISTER_ADDRESS_WIDTH-1:0] w_sel_address;
    logic [DATA_WIDTH-1:0]             w_sel_data;

    // Reset blocks grants exactly like a stall so nothing transfers during it.
    rf_rr_grant2 u_grant (
        .valid  (bus.req_valid),
        .hold   (hold | s_reset),
        .rr_ptr (r_rr_ptr),
        .grant  (w_grant)
    );

    assign bus.req_ready = w_grant;
    assign w_xfer        = |(bus.req_valid & w_grant);
    assign w_sel         = w_grant[rf_pkg::REQ_LSU];
    assign w_sel_address = bus.req_address[w_sel];
    assign w_sel_data    = bus.req_data[w_sel];

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_rr_ptr        <= 1'b0;
            r_rf_we         <= 1'b0;
            r_rf_address    <= '0;
            r_rf_write_data <= '0;
        end else begin
            // Writes to register 0 are consumed but never reach the file.
            r_rf_we <= w_xfer && (w_sel_address != '0);
            if (w_xfer) begin
                r_rf_address    <= w_sel_address;
                r_rf_write_data <= w_sel_data;
                r_rr_ptr        <= ~w_sel;
            end
        end
    end

    assign bus.rf_we         = r_rf_we;
    assign bus.rf_address    = r_rf_address;
    assign bus.rf_write_data = r_rf_write_data;

`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
    logic [15:0] r_conflict_count;
    logic        w_conflict;

    assign w_conflict = (&bus.req_valid) & ~hold;

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_conflict_count <= 16'h0000;
        end else if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'h0001;
        end
    end

    assign conflict_count = r_conflict_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
//==============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Scoreboard bench for rf_wb_arbiter: directed scenarios followed
//               by randomized traffic against a rotating-priority reference.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rf_wb_arbiter;
    import rf_pkg::*;

    typedef struct packed {
        logic     we;
        rf_addr_t addr;
        rf_data_t data;
    } exp_t;

    logic clk = 1'b0;
    logic s_reset;
    logic hold;

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
    logic [15:0] conflict_count;
    int          model_conf = 0;
`endif

    rf_wb_arbiter #(
        .REGISTER_ADDRESS_WIDTH (REGISTER_ADDRESS_WIDTH),
        .DATA_WIDTH             (DATA_WIDTH)
    ) dut (
        .clk            (clk),
        .s_reset        (s_reset),
        .hold           (hold),
        .bus            (bus)
`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    int         grant_log[$];
    int         model_fav  = 0;
    rf_addr_t   model_addr = '0;
    rf_data_t   model_data = '0;
    logic [1:0] model_grant = 2'b00;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: favoured requester first, then the other; decided at negedge.
    always @(negedge clk) begin : p_model
        int         winner;
        logic [1:0] g;
        exp_t       e;
        winner = -1;
        if (!s_reset && !hold) begin
            if (bus.req_valid[model_fav])          winner = model_fav;
            else if (bus.req_valid[1 - model_fav]) winner = 1 - model_fav;
        end
        g = 2'b00;
        if (winner >= 0) g[winner] = 1'b1;
        checks++;
        if (bus.req_ready !== g) begin
            errors++;
            $display("FAIL req_ready @%0t: got %b expected %b", $time, bus.req_ready, g);
        end
        if (s_reset) begin
            model_fav  = 0;
            model_addr = '0;
            model_data = '0;
            e = '{we: 1'b0, addr: '0, data: '0};
        end else if (winner >= 0) begin
            model_addr = bus.req_address[winner];
            model_data = bus.req_data[winner];
            model_fav  = 1 - winner;
            grant_log.push_back(winner);
            e = '{we: (model_addr != 0), addr: model_addr, data: model_data};
        end else begin
            e = '{we: 1'b0, addr: model_addr, data: model_data};
        end
`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
        if (s_reset) model_conf = 0;
        else if (bus.req_valid == 2'b11 && !hold && model_conf < 65535) model_conf++;
`endif
        exp_q.push_back(e);
        model_grant = g;
    end

    // Monitor: compares the registered write port shortly after every edge.
    always @(posedge clk) begin : p_monitor
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== e.we || bus.rf_address !== e.addr || bus.rf_write_data !== e.data) begin
                errors++;
                $display("FAIL rf_port @%0t: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                         $time, bus.rf_we, bus.rf_address, bus.rf_write_data, e.we, e.addr, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq[4];
        exp_seq = '{0, 1, 0, 1};

        s_reset             = 1'b1;
        hold                = 1'b0;
        bus.req_valid       = 2'b11;
        bus.req_address[0]  = rf_addr_t'(3);
        bus.req_address[1]  = rf_addr_t'(7);
        bus.req_data[0]     = rf_data_t'(32'h11);
        bus.req_data[1]     = rf_data_t'(32'h22);

        // Reset with both requesters pending
        step();
        check("reset_we", 64'(bus.rf_we), 64'd0);
        check("reset_addr", 64'(bus.rf_address), 64'd0);
        step();
        s_reset = 1'b0;

        // Contention: four grants alternating from requester 0
        grant_log.delete();
        repeat (4) step();
        check("contention_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("contention_grant%0d", i), 64'(grant_log[i]), 64'(exp_seq[i]));
        grant_log.delete();

        // Single ALU request
        bus.req_valid      = 2'b01;
        bus.req_address[0] = rf_addr_t'(5);
        bus.req_data[0]    = rf_data_t'(32'hDEADBEEF);
        step();
        check("single_we", 64'(bus.rf_we), 64'd1);
        check("single_addr", 64'(bus.rf_address), 64'd5);
        check("single_data", 64'(bus.rf_write_data), 64'hDEADBEEF);

        // LSU write to register 0: accepted, no write enable
        bus.req_valid      = 2'b10;
        bus.req_address[1] = '0;
        bus.req_data[1]    = rf_data_t'(32'hFFFF_FFFF);
        step();
        check("zero_we", 64'(bus.rf_we), 64'd0);
        check("zero_data", 64'(bus.rf_write_data), 64'hFFFF_FFFF);

        // Stall with both pending, then release
        bus.req_valid = 2'b11;
        hold          = 1'b1;
        repeat (3) begin
            step();
            check("hold_we", 64'(bus.rf_we), 64'd0);
        end
        hold = 1'b0;
        step();
        check("post_zero_grants", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() > 0)
            check("hold_release_grant", 64'(grant_log[grant_log.size() - 1]), 64'(REQ_ALU));

        // Randomized traffic; requests stay stable until granted
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (model_grant[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && $urandom_range(0, 99) < 65) begin
                    bus.req_valid[i]   = 1'b1;
                    bus.req_address[i] = ($urandom_range(0, 7) == 0) ? '0 : rf_addr_t'($urandom);
                    bus.req_data[i]    = rf_data_t'($urandom);
                end
            end
            hold    = ($urandom_range(0, 9) == 0);
            s_reset = ($urandom_range(0, 39) == 0);
            step();
        end
        s_reset       = 1'b0;
        hold          = 1'b0;
        bus.req_valid = 2'b00;
        step();
        step();
`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
        check("conflict_random", 64'(conflict_count), 64'(model_conf));
`endif

        // Ten contended cycles followed by five stalled ones
        s_reset       = 1'b1;
        bus.req_valid = 2'b11;
        step();
        s_reset = 1'b0;
        repeat (10) step();
        hold = 1'b1;
        repeat (5) step();
`ifdef RF_WB_ARBITER_CONFLICT_CNT_EN
        check("conflict_count", 64'(conflict_count), 64'd10);
`endif
        hold          = 1'b0;
        bus.req_valid = 2'b00;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
